// File: rtl/mealy_pkg.sv
// Shared types and transition function for the 4-state A/B/C/D Mealy machine.
// The decoder and its bench model import next_state() from here so all agree on the table.
package mealy_pkg;

    typedef enum logic [1:0] {
        S_A = 2'b00,
        S_B = 2'b01,
        S_C = 2'b10,
        S_D = 2'b11
    } state_t;

    function automatic state_t next_state(input state_t cur, input logic in);
        state_t nxt;
        nxt = S_A;
        case (cur)
            S_A: nxt = in ? S_A : S_B;
            S_B: nxt = in ? S_A : S_C;
            S_C: nxt = in ? S_B : S_D;
            S_D: nxt = in ? S_C : S_A;
            default: nxt = S_A;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mealy_dwell_ctr.sv
// Saturating dwell counter: clear wins over inc, holds at all-ones,
// and flags when the count equals the timeout threshold.
module mealy_dwell_ctr #(
    parameter int unsigned DWELL_W = 4,
    parameter int unsigned TIMEOUT = 12
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clear,
    input  logic               inc,
    output logic [DWELL_W-1:0] count,
    output logic               at_limit
);

    localparam logic [DWELL_W-1:0] LIMIT = DWELL_W'(TIMEOUT);
    localparam logic [DWELL_W-1:0] ONE   = DWELL_W'(1);

    logic [DWELL_W-1:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + ONE;
        end
    end

    assign count    = r_count;
    assign at_limit = (r_count == LIMIT);

endmodule

// File: rtl/mealy_state_seq.sv
// State register and next-state logic for the A/B/C/D Mealy machine, with
// load path, dwell-timeout recovery to A, and registered change/timeout pulses.
module mealy_state_seq
    import mealy_pkg::*;
#(
    parameter int unsigned DWELL_W = 4,
    parameter int unsigned TIMEOUT = 12
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               en,
    input  logic               in,
    input  logic               load,
    input  logic [1:0]         load_state,
    output logic [1:0]         state,
    output logic [1:0]         prev_state,
    output logic               changed,
    output logic               timeout,
    output logic [DWELL_W-1:0] dwell
);

    state_t             r_state;
    state_t             r_prev;
    logic               r_changed;
    logic               r_timeout;

    state_t             w_state_nxt;
    state_t             w_prev_nxt;
    state_t             w_step;
    logic               w_tmo_hit;
    logic               w_moved;
    logic               w_changed_nxt;
    logic               w_timeout_nxt;
    logic               w_dwell_clr;
    logic [DWELL_W-1:0] w_dwell;
    logic               w_at_limit;

    mealy_dwell_ctr #(
        .DWELL_W (DWELL_W),
        .TIMEOUT (TIMEOUT)
    ) u_dwell (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (w_dwell_clr),
        .inc      (!w_dwell_clr),
        .count    (w_dwell),
        .at_limit (w_at_limit)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_A;
            r_prev    <= S_A;
            r_changed <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_prev    <= w_prev_nxt;
            r_changed <= w_changed_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    // Priority: load > timeout > table step (en) > hold.
    always_comb begin
        w_step      = next_state(r_state, in);
        w_state_nxt = r_state;
        w_tmo_hit   = 1'b0;
        if (load) begin
            w_state_nxt = state_t'(load_state);
        end else if (en && w_at_limit) begin
            w_state_nxt = S_A;
            w_tmo_hit   = 1'b1;
        end else if (en) begin
            w_state_nxt = w_step;
        end
        w_moved     = (w_state_nxt != r_state);
        // Dwell restarts on any load, any timeout, or any real state change;
        // self-loops and idle (en=0) cycles keep counting.
        w_dwell_clr = load || w_tmo_hit || w_moved;
    end

    always_comb begin
        w_prev_nxt    = w_moved ? r_state : r_prev;
        w_changed_nxt = w_moved;
        w_timeout_nxt = w_tmo_hit;
    end

    assign state      = r_state;
    assign prev_state = r_prev;
    assign changed    = r_changed;
    assign timeout    = r_timeout;
    assign dwell      = w_dwell;

endmodule

// File: tb/tb_mealy_state_seq.sv
// Directed bench for mealy_state_seq: a table of single-edge vectors plus
// hand-written sequences for timeout, saturation, load priority and mid-run reset.
module tb_mealy_state_seq;

    logic       clk;
    logic       reset_n;
    logic       en;
    logic       in;
    logic       load;
    logic [1:0] load_state;
    logic [1:0] state;
    logic [1:0] prev_state;
    logic       changed;
    logic       timeout;
    logic [3:0] dwell;

    int unsigned n_cmp;
    int unsigned n_err;

    mealy_state_seq #(
        .DWELL_W (4),
        .TIMEOUT (12)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (en),
        .in         (in),
        .load       (load),
        .load_state (load_state),
        .state      (state),
        .prev_state (prev_state),
        .changed    (changed),
        .timeout    (timeout),
        .dwell      (dwell)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       in;
        logic       load;
        logic [1:0] ld;
        logic [1:0] st;
        logic [1:0] pv;
        logic       ch;
        logic       to;
        logic [3:0] dw;
    } vec_t;

    vec_t vecs [19];

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic [1:0] st, input logic [1:0] pv,
                             input logic ch, input logic to, input logic [3:0] dw);
        check({tag, ".state"},      state,      st);
        check({tag, ".prev_state"}, prev_state, pv);
        check({tag, ".changed"},    changed,    ch);
        check({tag, ".timeout"},    timeout,    to);
        check({tag, ".dwell"},      dwell,      dw);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic i, input logic l, input logic [1:0] ls);
        en         = e;
        in         = i;
        load       = l;
        load_state = ls;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        //           en in ld lds   st    pv    ch to dw
        vecs[0]  = '{1, 0, 0, 2'd0, 2'd1, 2'd0, 1, 0, 4'd0};
        vecs[1]  = '{1, 0, 0, 2'd0, 2'd2, 2'd1, 1, 0, 4'd0};
        vecs[2]  = '{1, 0, 0, 2'd0, 2'd3, 2'd2, 1, 0, 4'd0};
        vecs[3]  = '{1, 0, 0, 2'd0, 2'd0, 2'd3, 1, 0, 4'd0};
        vecs[4]  = '{1, 0, 0, 2'd0, 2'd1, 2'd0, 1, 0, 4'd0};
        vecs[5]  = '{1, 0, 0, 2'd0, 2'd2, 2'd1, 1, 0, 4'd0};
        vecs[6]  = '{1, 1, 0, 2'd0, 2'd1, 2'd2, 1, 0, 4'd0};
        vecs[7]  = '{1, 0, 0, 2'd0, 2'd2, 2'd1, 1, 0, 4'd0};
        vecs[8]  = '{1, 0, 0, 2'd0, 2'd3, 2'd2, 1, 0, 4'd0};
        vecs[9]  = '{1, 1, 0, 2'd0, 2'd2, 2'd3, 1, 0, 4'd0};
        vecs[10] = '{1, 1, 0, 2'd0, 2'd1, 2'd2, 1, 0, 4'd0};
        vecs[11] = '{1, 1, 0, 2'd0, 2'd0, 2'd1, 1, 0, 4'd0};
        vecs[12] = '{0, 0, 0, 2'd0, 2'd0, 2'd1, 0, 0, 4'd1};
        vecs[13] = '{1, 0, 1, 2'd1, 2'd1, 2'd0, 1, 0, 4'd0};
        vecs[14] = '{1, 0, 1, 2'd3, 2'd3, 2'd1, 1, 0, 4'd0};
        vecs[15] = '{1, 0, 1, 2'd3, 2'd3, 2'd1, 0, 0, 4'd0};
        vecs[16] = '{0, 0, 0, 2'd0, 2'd3, 2'd1, 0, 0, 4'd1};
        vecs[17] = '{0, 0, 0, 2'd0, 2'd3, 2'd1, 0, 0, 4'd2};
        vecs[18] = '{0, 0, 1, 2'd0, 2'd0, 2'd3, 1, 0, 4'd0};

        reset_n = 1'b0;
        drive(0, 0, 0, 2'd0);
        cyc();
        cyc();
        check_all("reset", 2'd0, 2'd0, 0, 0, 4'd0);
        reset_n = 1'b1;

        foreach (vecs[k]) begin
            drive(vecs[k].en, vecs[k].in, vecs[k].load, vecs[k].ld);
            cyc();
            check_all($sformatf("vec%0d", k), vecs[k].st, vecs[k].pv, vecs[k].ch, vecs[k].to, vecs[k].dw);
        end

        // Self-loop at A until the dwell threshold forces a timeout.
        drive(1, 1, 0, 2'd0);
        for (int i = 1; i <= 12; i++) begin
            cyc();
            check_all($sformatf("selfloop%0d", i), 2'd0, 2'd3, 0, 0, 4'(i));
        end
        cyc();
        check_all("tmo_at_A", 2'd0, 2'd3, 0, 1, 4'd0);
        cyc();
        check_all("tmo_after", 2'd0, 2'd3, 0, 0, 4'd1);

        // Idle dwell saturates at 15 and never fires a timeout.
        drive(0, 0, 0, 2'd0);
        for (int k = 1; k <= 20; k++) begin
            cyc();
            check($sformatf("sat%0d.dwell", k), dwell, (1 + k > 15) ? 15 : 1 + k);
            check($sformatf("sat%0d.timeout", k), timeout, 0);
            check($sformatf("sat%0d.state", k), state, 0);
        end
        drive(1, 1, 0, 2'd0);
        cyc();
        check_all("sat_en", 2'd0, 2'd3, 0, 0, 4'd15);

        // Load beats a pending timeout.
        drive(0, 0, 1, 2'd1);
        cyc();
        check_all("ldB", 2'd1, 2'd0, 1, 0, 4'd0);
        drive(0, 0, 0, 2'd0);
        repeat (12) cyc();
        check("idle12.dwell", dwell, 12);
        drive(1, 0, 1, 2'd2);
        cyc();
        check_all("ld_over_tmo", 2'd2, 2'd1, 1, 0, 4'd0);

        // Timeout beats the table step from a non-A state.
        drive(0, 0, 0, 2'd0);
        repeat (12) cyc();
        check("idle12b.dwell", dwell, 12);
        drive(1, 0, 0, 2'd0);
        cyc();
        check_all("tmo_from_C", 2'd0, 2'd2, 1, 1, 4'd0);

        // Asynchronous reset mid-run.
        drive(0, 0, 1, 2'd3);
        cyc();
        check_all("ldD", 2'd3, 2'd0, 1, 0, 4'd0);
        drive(0, 0, 0, 2'd0);
        #3;
        reset_n = 1'b0;
        #1;
        check_all("async_rst", 2'd0, 2'd0, 0, 0, 4'd0);
        cyc();
        check_all("rst_held", 2'd0, 2'd0, 0, 0, 4'd0);
        reset_n = 1'b1;
        cyc();
        check_all("post_rst1", 2'd0, 2'd0, 0, 0, 4'd1);
        cyc();
        check_all("post_rst2", 2'd0, 2'd0, 0, 0, 4'd2);
        drive(1, 0, 0, 2'd0);
        cyc();
        check_all("post_rst_step", 2'd1, 2'd0, 1, 0, 4'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
